// File: rtl/cpu_io_hub.sv
// cpu_io_hub: data-side bus hub for the single-cycle CPU.
// Contains a word RAM, N_OUT memory-mapped output channels, a free-running
// cycle counter and a run/drain/halt controller that stops the core a fixed
// number of cycles after the PC reaches LAST_PC or after a software halt write.
// Optional trace output: define CPU_IO_HUB_TRACE_EN to print committed writes
// and the HALTED entry in simulation. It has no effect on port behaviour.
module cpu_io_hub #(
  parameter int          RAM_AW    = 5,
  parameter int          N_OUT     = 2,
  parameter int          OUT_W     = 16,
  parameter int          LAST_PC   = 31,
  parameter int          DRAIN_CYC = 2,
  parameter logic [31:0] IO_BASE   = 32'h8000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            instr_addr,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_data,
  input  logic                   mem_we,
  input  logic                   mem_re,
  output logic [31:0]            mem_rdata,
  output logic                   core_en,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic [N_OUT-1:0]       out_stb,
  output logic                   halted
);

  localparam int DEPTH = 1 << RAM_AW;

  // Controller states.
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // A zero drain period behaves like a one-cycle drain.
  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYC < 1) ? 32'd1 : 32'(DRAIN_CYC);
  localparam logic [29:0] LAST_PC_W  = 30'(LAST_PC);

  // I/O word offsets relative to IO_BASE.
  localparam logic [29:0] IO_CNT_WORD  = 30'd64;   // IO_BASE + 0x100
  localparam logic [29:0] IO_HALT_WORD = 30'd65;   // IO_BASE + 0x104

  logic [31:0]            r_ram [DEPTH];
  logic [31:0]            r_rdata;
  logic [N_OUT*OUT_W-1:0] r_out_data;
  logic [N_OUT-1:0]       r_out_stb;
  logic [31:0]            r_cycle;
  logic [1:0]             r_state;
  logic [31:0]            r_drain_cnt;

  logic              w_is_io;
  logic [31:0]       w_io_off;
  logic [29:0]       w_io_word;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_wr_ok;
  logic              w_ram_we;
  logic              w_halt_wr;
  logic              w_trigger;
  logic [N_OUT-1:0]  w_ch_we;
  logic [31:0]       w_rd_val;
  logic              w_unused;

  // Address decode shared by the read and write paths.
  assign w_is_io   = (mem_addr >= IO_BASE);
  assign w_io_off  = mem_addr - IO_BASE;
  assign w_io_word = w_io_off[31:2];
  assign w_ram_idx = mem_addr[RAM_AW+1:2];

  // Nothing is written once the core is halted.
  assign w_wr_ok   = mem_we && (r_state != ST_HALTED);
  assign w_ram_we  = w_wr_ok && !w_is_io;
  assign w_halt_wr = w_wr_ok && w_is_io && (w_io_word == IO_HALT_WORD);
  assign w_trigger = (instr_addr[31:2] == LAST_PC_W) || w_halt_wr;

  // Byte-offset bits below word granularity carry no information here.
  assign w_unused = ^{instr_addr[1:0], w_io_off[1:0]};

  // Per-channel write enables.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_ch_we = '0;
    for (int i = 0; i < N_OUT; i++) begin
      w_ch_we[i] = w_wr_ok && w_is_io && (w_io_word == 30'(i));
    end
  end

  // Read mux: value presented at the current address, captured on mem_re.
  always_comb begin
    w_rd_val = '0;
    if (!w_is_io) begin
      w_rd_val = r_ram[w_ram_idx];
    end else if (w_io_word == IO_CNT_WORD) begin
      w_rd_val = r_cycle;
    end else if (w_io_word == IO_HALT_WORD) begin
      w_rd_val = {30'b0, (r_state == ST_HALTED), (r_state == ST_DRAIN)};
    end else begin
      for (int i = 0; i < N_OUT; i++) begin
        if (w_io_word == 30'(i)) begin
          w_rd_val = 32'(r_out_data[i*OUT_W +: OUT_W]);
        end
      end
    end
  end

  // Word RAM write port.
  always_ff @(posedge clk) begin
    // NOTE: RAM contents are deliberately not reset so the array maps onto memory primitives.
    if (w_ram_we) begin
      r_ram[w_ram_idx] <= mem_data;
    end
  end

  // Registered read data; holds between reads. Same-edge writes are not yet visible.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_rdata <= '0;
    end else if (mem_re) begin
      r_rdata <= w_rd_val;
    end
  end

  // Output channel registers and their one-cycle write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data <= '0;
      r_out_stb  <= '0;
    end else begin
      r_out_stb <= w_ch_we;
      for (int i = 0; i < N_OUT; i++) begin
        if (w_ch_we[i]) begin
          r_out_data[i*OUT_W +: OUT_W] <= mem_data[OUT_W-1:0];
        end
      end
    end
  end

  // Cycle counter: counts while the core runs or drains, frozen once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else if (r_state != ST_HALTED) begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  // Run/drain/halt controller. Triggers seen while draining do not restart the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_trigger) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt <= 32'd1) begin
            r_state <= ST_HALTED;
          end else begin
            r_drain_cnt <= r_drain_cnt - 32'd1;
          end
        end
        ST_HALTED: begin
          r_state <= ST_HALTED;
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef CPU_IO_HUB_TRACE_EN
  // Simulation trace of committed writes and of the halt event.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_ok) begin
      $display("%4d W> addr:%h data:%h", r_cycle, mem_addr, mem_data);
    end
    if (!rst && (r_state == ST_DRAIN) && (r_drain_cnt <= 32'd1)) begin
      $display("%4d H> cycles:%d", r_cycle, r_cycle + 32'd1);
    end
  end
`else
  // Default build: no trace logic.
`endif

  assign mem_rdata = r_rdata;
  assign out_data  = r_out_data;
  assign out_stb   = r_out_stb;
  assign core_en   = (r_state != ST_HALTED);
  assign halted    = (r_state == ST_HALTED);

endmodule

// File: tb/tb_cpu_io_hub.sv
// Directed testbench for cpu_io_hub with default parameters
// (RAM_AW=5, N_OUT=2, OUT_W=16, LAST_PC=31, DRAIN_CYC=2, IO_BASE=0x8000).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_cpu_io_hub;

  logic        clk;
  logic        rst;
  logic [31:0] instr_addr;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic        core_en;
  logic [31:0] out_data;
  logic [1:0]  out_stb;
  logic        halted;

  int errors = 0;
  int checks = 0;

  logic [31:0] v_first;

  cpu_io_hub dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
    .core_en    (core_en),
    .out_data   (out_data),
    .out_stb    (out_stb),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_we = 1'b0;
    mem_re = 1'b0;
    mem_addr = 32'h0;
    mem_data = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    instr_addr = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got=%h exp=%h", out_data, 32'h0); end
    checks++; if (out_stb !== 2'b00) begin errors++; $display("FAIL rst_out_stb got=%b exp=%b", out_stb, 2'b00); end
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL rst_core_en got=%b exp=1", core_en); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=%h", mem_rdata, 32'h0); end
    // Counter read on the first edge after reset sees 0.
    mem_re = 1'b1; mem_addr = 32'h8100;
    tick();
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_counter got=%h exp=%h", mem_rdata, 32'h0); end
    mem_re = 1'b0;
    tick();
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rdata_hold got=%h exp=%h", mem_rdata, 32'h0); end
    tick();
    // Counter incremented on edges 1, 2 and 3; edge 4 captures 3.
    mem_re = 1'b1;
    tick();
    checks++; if (mem_rdata !== 32'd3) begin errors++; $display("FAIL counter_run got=%h exp=%h", mem_rdata, 32'd3); end
    idle();
  endtask

  task automatic test_ram();
    do_reset();
    mem_we = 1'b1; mem_addr = 32'h0C; mem_data = 32'hDEADBEEF;
    tick();
    mem_we = 1'b0; mem_re = 1'b1;
    tick();
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_read got=%h exp=%h", mem_rdata, 32'hDEADBEEF); end
    // Same-address write and read in one cycle returns the old word.
    mem_we = 1'b1; mem_data = 32'h12345678;
    tick();
    checks++; if (mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd_old got=%h exp=%h", mem_rdata, 32'hDEADBEEF); end
    mem_we = 1'b0;
    tick();
    checks++; if (mem_rdata !== 32'h12345678) begin errors++; $display("FAIL ram_rd_new got=%h exp=%h", mem_rdata, 32'h12345678); end
    // 32-word RAM aliases: byte 0x8C maps to word 3.
    mem_addr = 32'h8C;
    mem_we = 1'b1; mem_data = 32'hCAFEF00D;
    tick();
    mem_we = 1'b0; mem_addr = 32'h0C;
    tick();
    checks++; if (mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL ram_alias got=%h exp=%h", mem_rdata, 32'hCAFEF00D); end
    idle();
  endtask

  task automatic test_channels();
    do_reset();
    mem_we = 1'b1; mem_addr = 32'h8004; mem_data = 32'h0001ABCD;
    tick();
    checks++; if (out_data !== 32'hABCD0000) begin errors++; $display("FAIL ch1_data got=%h exp=%h", out_data, 32'hABCD0000); end
    checks++; if (out_stb !== 2'b10) begin errors++; $display("FAIL ch1_stb got=%b exp=%b", out_stb, 2'b10); end
    mem_we = 1'b0; mem_re = 1'b1;
    tick();
    checks++; if (out_stb !== 2'b00) begin errors++; $display("FAIL ch1_stb_clear got=%b exp=%b", out_stb, 2'b00); end
    checks++; if (mem_rdata !== 32'h0000ABCD) begin errors++; $display("FAIL ch1_read got=%h exp=%h", mem_rdata, 32'h0000ABCD); end
    mem_re = 1'b0; mem_we = 1'b1; mem_addr = 32'h8000; mem_data = 32'hFFFF1234;
    tick();
    checks++; if (out_data !== 32'hABCD1234) begin errors++; $display("FAIL ch0_data got=%h exp=%h", out_data, 32'hABCD1234); end
    checks++; if (out_stb !== 2'b01) begin errors++; $display("FAIL ch0_stb got=%b exp=%b", out_stb, 2'b01); end
    // Unmapped I/O: write ignored, read returns 0.
    mem_addr = 32'h8008; mem_data = 32'h5A5A5A5A; mem_re = 1'b1;
    tick();
    checks++; if (out_data !== 32'hABCD1234) begin errors++; $display("FAIL unmapped_wr got=%h exp=%h", out_data, 32'hABCD1234); end
    checks++; if (out_stb !== 2'b00) begin errors++; $display("FAIL unmapped_stb got=%b exp=%b", out_stb, 2'b00); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL unmapped_rd got=%h exp=%h", mem_rdata, 32'h0); end
    idle();
  endtask

  task automatic test_pc_halt();
    do_reset();
    // PC reaches LAST_PC while a channel write happens in the same cycle.
    instr_addr = 32'h7C;
    mem_we = 1'b1; mem_addr = 32'h8000; mem_data = 32'h00000042;
    tick();
    checks++; if (out_data !== 32'h00000042) begin errors++; $display("FAIL trig_wr_data got=%h exp=%h", out_data, 32'h00000042); end
    checks++; if (out_stb !== 2'b01) begin errors++; $display("FAIL trig_wr_stb got=%b exp=%b", out_stb, 2'b01); end
    checks++; if (halted !== 1'b0 || core_en !== 1'b1) begin errors++; $display("FAIL drain1 got=%b%b exp=01", halted, core_en); end
    // Still draining: write accepted, status reads drain_active. PC stays at LAST_PC.
    mem_addr = 32'h8004; mem_data = 32'h00000009;
    tick();
    mem_we = 1'b0; mem_re = 1'b1; mem_addr = 32'h8104;
    checks++; if (out_data !== 32'h00090042) begin errors++; $display("FAIL drain_wr got=%h exp=%h", out_data, 32'h00090042); end
    checks++; if (halted !== 1'b0 || core_en !== 1'b1) begin errors++; $display("FAIL drain2 got=%b%b exp=01", halted, core_en); end
    tick();
    checks++; if (halted !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL halt_pc got=%b%b exp=10", halted, core_en); end
    checks++; if (mem_rdata !== 32'h1) begin errors++; $display("FAIL status_drain got=%h exp=%h", mem_rdata, 32'h1); end
    tick();
    checks++; if (mem_rdata !== 32'h2) begin errors++; $display("FAIL status_halt got=%h exp=%h", mem_rdata, 32'h2); end
    // Writes ignored while halted; reads still served.
    mem_re = 1'b0; mem_we = 1'b1; mem_addr = 32'h8000; mem_data = 32'h00005555;
    tick();
    checks++; if (out_data !== 32'h00090042) begin errors++; $display("FAIL halt_wr_ign got=%h exp=%h", out_data, 32'h00090042); end
    checks++; if (out_stb !== 2'b00) begin errors++; $display("FAIL halt_stb got=%b exp=%b", out_stb, 2'b00); end
    mem_we = 1'b0; mem_re = 1'b1;
    tick();
    checks++; if (mem_rdata !== 32'h00000042) begin errors++; $display("FAIL halt_rd got=%h exp=%h", mem_rdata, 32'h00000042); end
    idle();
    instr_addr = 32'h0;
  endtask

  task automatic test_sw_halt();
    do_reset();
    // Edge 1 takes the halt write; counter runs on edges 1..3 then freezes at 3.
    mem_we = 1'b1; mem_addr = 32'h8104; mem_data = 32'hFFFFFFFF;
    tick();
    mem_we = 1'b0;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sw_drain1 got=%b exp=0", halted); end
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL sw_drain2 got=%b exp=0", halted); end
    tick();
    checks++; if (halted !== 1'b1 || core_en !== 1'b0) begin errors++; $display("FAIL sw_halt got=%b%b exp=10", halted, core_en); end
    mem_re = 1'b1; mem_addr = 32'h8100;
    tick();
    checks++; if (mem_rdata !== 32'd3) begin errors++; $display("FAIL sw_counter got=%h exp=%h", mem_rdata, 32'd3); end
    v_first = mem_rdata;
    mem_re = 1'b0;
    repeat (10) tick();
    mem_re = 1'b1;
    tick();
    checks++; if (mem_rdata !== v_first) begin errors++; $display("FAIL counter_frozen got=%h exp=%h", mem_rdata, v_first); end
    idle();
  endtask

  task automatic test_rst_drain();
    do_reset();
    instr_addr = 32'h7C;
    mem_we = 1'b1; mem_addr = 32'h8004; mem_data = 32'h0000BEEF;
    tick();
    // Mid-drain reset, with a strobe pending.
    idle();
    instr_addr = 32'h0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (halted !== 1'b0 || core_en !== 1'b1) begin errors++; $display("FAIL rst_drain_state got=%b%b exp=01", halted, core_en); end
    checks++; if (out_stb !== 2'b00 || out_data !== 32'h0) begin errors++; $display("FAIL rst_drain_out got=%b/%h exp=00/%h", out_stb, out_data, 32'h0); end
    mem_re = 1'b1; mem_addr = 32'h8100;
    tick();
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_drain_cnt got=%h exp=%h", mem_rdata, 32'h0); end
    mem_re = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_drain_nohalt cyc=%0d got=%b exp=0", i, halted); end
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    instr_addr = 32'h0;
    idle();
    test_reset();
    test_ram();
    test_channels();
    test_pc_halt();
    test_sw_halt();
    test_rst_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
